// File: rtl/mandel_iter_engine_if.sv
// Pixel request/response bundle between the coordinate generator and mandel_iter_engine.
// The master issues c and start; the slave (engine) reports the escape count.
interface mandel_iter_engine_if #(
  parameter int unsigned CNT_W = 8
);
  logic                start;
  logic signed [10:0]  cx;
  logic signed [10:0]  cy;
  logic                ready;
  logic                done;
  logic [CNT_W-1:0]    iter_count;
  logic                in_set;

  modport master (
    output start, cx, cy,
    input  ready, done, iter_count, in_set
  );

  modport slave (
    input  start, cx, cy,
    output ready, done, iter_count, in_set
  );
endinterface

// File: rtl/mandel_iter_engine.sv
// Mandelbrot escape-time iterator for one pixel: z <- z^2 + c in Q3.8, sharing a single
// pipelined signed_multiplier for x*x, y*y and x*y on successive cycles.

module signed_multiplier #(
  parameter int unsigned A_W = 11,
  parameter int unsigned B_W = 11,
  parameter int unsigned LAT = 3
) (
  input  logic                       clk,
  input  logic                       ce,
  input  logic signed [A_W-1:0]      a,
  input  logic signed [B_W-1:0]      b,
  output logic signed [A_W+B_W-1:0]  p
);
  logic signed [A_W+B_W-1:0] pipe [LAT];

  always_ff @(posedge clk) begin
    if (ce) begin
      pipe[0] <= a * b;
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign p = pipe[LAT-1];
endmodule

module mandel_iter_engine #(
  parameter int unsigned MAX_ITER = 255,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MULT_LAT = 3
) (
  input logic                 clk,
  input logic                 rst,
  mandel_iter_engine_if.slave bus
);
  localparam int unsigned PH_W = $clog2(MULT_LAT + 3);
  localparam logic [PH_W-1:0] PH_XX = PH_W'(MULT_LAT);
  localparam logic [PH_W-1:0] PH_YY = PH_W'(MULT_LAT + 1);
  localparam logic [PH_W-1:0] PH_XY = PH_W'(MULT_LAT + 2);
  localparam logic [22:0]     FOUR  = 23'd262144;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [PH_W-1:0]    phase_q;
  logic signed [10:0] cx_q, cy_q, x_q, y_q;
  logic [CNT_W-1:0]   iter_q;
  logic signed [21:0] xx_q, yy_q, xy_q;
  logic [CNT_W-1:0]   iter_count_q;
  logic               in_set_q;

  logic signed [10:0] mul_a, mul_b;
  logic signed [21:0] mul_p;

  logic [22:0]        mag;
  logic               esc, max_hit;
  logic signed [22:0] diff, diff_sh, dbl, dbl_sh;
  logic signed [23:0] x_sum, y_sum;
  logic signed [10:0] x_next, y_next;

  function automatic logic signed [10:0] sat11(input logic signed [23:0] v);
    if (v > 24'sd1023)
      return 11'sh3FF;
    else if (v < -24'sd1024)
      return 11'sh400;
    else
      return v[10:0];
  endfunction

  signed_multiplier #(
    .A_W (11),
    .B_W (11),
    .LAT (MULT_LAT)
  ) u_mult (
    .clk (clk),
    .ce  (1'b1),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  always_comb begin
    mag     = {1'b0, xx_q} + {1'b0, yy_q};
    esc     = (mag > FOUR);
    max_hit = (iter_q == CNT_W'(MAX_ITER));
    diff    = 23'(xx_q) - 23'(yy_q);
    diff_sh = diff >>> 8;
    dbl     = 23'(xy_q) <<< 1;
    dbl_sh  = dbl >>> 8;
    x_sum   = 24'(diff_sh) + 24'(cx_q);
    y_sum   = 24'(dbl_sh) + 24'(cy_q);
    x_next  = sat11(x_sum);
    y_next  = sat11(y_sum);
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mul_a   = x_q;
    mul_b   = x_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_MUL;
      S_MUL: begin
        if (phase_q == PH_W'(1)) begin
          mul_a = y_q;
          mul_b = y_q;
        end else if (phase_q == PH_W'(2)) begin
          mul_b = y_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT:   if (phase_q == PH_XY) state_d = S_UPDATE;
      S_UPDATE: state_d = (esc || max_hit) ? S_DONE : S_MUL;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Product capture is keyed only to phase_q, which restarts at every MUL entry, so
  // results still draining from an aborted run can never be latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      iter_q       <= '0;
      xx_q         <= '0;
      yy_q         <= '0;
      xy_q         <= '0;
      iter_count_q <= '0;
      in_set_q     <= 1'b0;
    end else begin
      if (state_q == S_MUL || state_q == S_WAIT) begin
        phase_q <= phase_q + PH_W'(1);
        if (phase_q == PH_XX) xx_q <= mul_p;
        if (phase_q == PH_YY) yy_q <= mul_p;
        if (phase_q == PH_XY) xy_q <= mul_p;
      end else begin
        phase_q <= '0;
      end

      if (state_q == S_IDLE && bus.start) begin
        cx_q   <= bus.cx;
        cy_q   <= bus.cy;
        x_q    <= '0;
        y_q    <= '0;
        iter_q <= '0;
      end

      if (state_q == S_UPDATE) begin
        if (esc) begin
          iter_count_q <= iter_q;
          in_set_q     <= 1'b0;
        end else if (max_hit) begin
          iter_count_q <= CNT_W'(MAX_ITER);
          in_set_q     <= 1'b1;
        end else begin
          x_q    <= x_next;
          y_q    <= y_next;
          iter_q <= iter_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.ready      = (state_q == S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.iter_count = iter_count_q;
  assign bus.in_set     = in_set_q;
endmodule

// File: tb/tb_mandel_iter_engine.sv
// Self-checking bench for mandel_iter_engine: directed vectors, corner sequences and
// random c values checked against a plain-integer escape-time model.
module tb_mandel_iter_engine;
  localparam int L        = 3;
  localparam int MAXI     = 255;
  localparam int ITER_CYC = L + 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mandel_iter_engine_if #(.CNT_W(8)) bus ();

  mandel_iter_engine #(
    .MAX_ITER (MAXI),
    .CNT_W    (8),
    .MULT_LAT (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [10:0] cx;
    logic [10:0] cy;
    int          n;
    bit          ins;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Escape-time reference computed directly on integers (Q3.8 values, Q6.16 products).
  function automatic void model(input logic [10:0] cx, input logic [10:0] cy,
                                output int n, output bit ins);
    int x, y, xx, yy, xy, icx, icy, nx, ny;
    icx = int'($signed(cx));
    icy = int'($signed(cy));
    x = 0;
    y = 0;
    n = MAXI;
    ins = 1'b1;
    for (int it = 0; it <= MAXI; it++) begin
      xx = x * x;
      yy = y * y;
      xy = x * y;
      if (xx + yy > 262144) begin
        n = it;
        ins = 1'b0;
        return;
      end
      nx = ((xx - yy) >>> 8) + icx;
      ny = ((2 * xy) >>> 8) + icy;
      x = (nx > 1023) ? 1023 : (nx < -1024) ? -1024 : nx;
      y = (ny > 1023) ? 1023 : (ny < -1024) ? -1024 : ny;
    end
  endfunction

  task automatic wait_done(input bit poke, output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    while (cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc >= 4 && cyc <= 8) begin
        bus.start = 1'b1;
        bus.cx = 11'h000;
        bus.cy = 11'h000;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int cyc, input bit ok,
                              input int exp_n, input bit exp_ins);
    check({tag, " done_seen"}, int'(ok), 1);
    if (ok) begin
      check({tag, " iter_count"}, int'(bus.iter_count), exp_n);
      check({tag, " in_set"}, int'(bus.in_set), int'(exp_ins));
      check({tag, " latency"}, cyc, (exp_n + 1) * ITER_CYC + 1);
    end
  endtask

  task automatic launch(input logic [10:0] cx, input logic [10:0] cy);
    int guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    bus.cx = cx;
    bus.cy = cy;
    bus.start = 1'b1;
  endtask

  task automatic run_and_check(input logic [10:0] cx, input logic [10:0] cy,
                               input int exp_n, input bit exp_ins,
                               input bit poke, input string tag);
    int cyc;
    bit ok;
    launch(cx, cy);
    wait_done(poke, cyc, ok);
    check_result(tag, cyc, ok, exp_n, exp_ins);
    @(negedge clk);
    check({tag, " pulse_width"}, int'(bus.done), 0);
    check({tag, " ready_back"}, int'(bus.ready), 1);
  endtask

  initial begin
    int cyc, n, dones;
    bit ok, ins;
    logic [10:0] rcx, rcy;

    vecs[0] = '{cx: 11'h000, cy: 11'h000, n: MAXI, ins: 1'b1};
    vecs[1] = '{cx: 11'h200, cy: 11'h000, n: 2,    ins: 1'b0};
    vecs[2] = '{cx: 11'h600, cy: 11'h000, n: MAXI, ins: 1'b1};
    vecs[3] = '{cx: 11'h100, cy: 11'h000, n: 3,    ins: 1'b0};
    vecs[4] = '{cx: 11'h000, cy: 11'h100, n: MAXI, ins: 1'b1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.cx = '0;
    bus.cy = '0;
    repeat (3) @(negedge clk);
    check("reset ready", int'(bus.ready), 1);
    check("reset done", int'(bus.done), 0);
    check("reset iter_count", int'(bus.iter_count), 0);
    check("reset in_set", int'(bus.in_set), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_and_check(vecs[i].cx, vecs[i].cy, vecs[i].n, vecs[i].ins, 1'b0,
                    $sformatf("vec%0d", i));
    end

    // Back-to-back: start is raised during the done cycle and held into the ready cycle.
    launch(11'h100, 11'h000);
    wait_done(1'b0, cyc, ok);
    check_result("b2b first", cyc, ok, 3, 1'b0);
    bus.cx = 11'h200;
    bus.cy = 11'h000;
    bus.start = 1'b1;
    @(negedge clk);
    check("b2b ready_rise", int'(bus.ready), 1);
    check("b2b done_low", int'(bus.done), 0);
    wait_done(1'b0, cyc, ok);
    check_result("b2b second", cyc, ok, 2, 1'b0);

    // Start pulses with a different c while busy must not disturb the running pixel.
    run_and_check(11'h100, 11'h000, 3, 1'b0, 1'b1, "busy_start");

    // Reset mid-run: immediate return to IDLE, cleared results, and no late done pulse.
    launch(11'h000, 11'h000);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst ready", int'(bus.ready), 1);
    check("midrst done", int'(bus.done), 0);
    check("midrst iter_count", int'(bus.iter_count), 0);
    check("midrst in_set", int'(bus.in_set), 0);
    dones = 0;
    repeat (2000) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst no_done", dones, 0);

    for (int r = 0; r < 16; r++) begin
      if (r[0]) begin
        rcx = 11'($urandom_range(0, 2047));
        rcy = 11'($urandom_range(0, 2047));
      end else begin
        rcx = 11'(int'($urandom_range(0, 640)) - 512);
        rcy = 11'(int'($urandom_range(0, 640)) - 320);
      end
      model(rcx, rcy, n, ins);
      run_and_check(rcx, rcy, n, ins, 1'b0,
                    $sformatf("rand%0d c=(%03h,%03h)", r, rcx, rcy));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
